// File: rtl/pulse_event_arbiter_pkg.sv
// Shared types and helpers for the pulse event arbiter.
package pulse_event_arbiter_pkg;

    typedef enum logic [0:0] {
        PEA_IDLE  = 1'b0,
        PEA_OFFER = 1'b1
    } pea_state_t;

    // Width of a channel index (ptr / evt_id); at least one bit.
    function automatic int pea_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-channel rising-edge detector with enable gating.
// The previous-level register resets high so a level held high through
// reset is not mistaken for a fresh edge.
module rise_detect (
    input  logic clk,
    input  logic rstn,
    input  logic lvl,
    input  logic en,
    output logic rise
);
    logic prev_p0;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (!rstn) prev_p0 <= 1'b1;
        else       prev_p0 <= lvl;
    end

    assign rise = lvl & ~prev_p0 & en;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Serialises rising-edge events from N_CH level inputs onto one
// valid/ready event port using round-robin arbitration, and counts
// events lost because the channel already had one pending.
module pulse_event_arbiter
    import pulse_event_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_CH-1:0]           lvl,
    input  logic [N_CH-1:0]           en_mask,
    output logic                      evt_valid,
    output logic [pea_id_w(N_CH)-1:0] evt_id,
    input  logic                      evt_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      drop_clr
);
    localparam int ID_W = pea_id_w(N_CH);

    pea_state_t      state_p0;
    logic [N_CH-1:0] pending_p0;
    logic [ID_W-1:0] ptr_p0;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr_vec;
    logic [N_CH-1:0] drop_vec;
    logic            any_drop;
    logic            accept;
    logic [ID_W-1:0] ptr_nxt;

    logic [N_CH-1:0] rot;
    logic            win_found;
    logic [ID_W-1:0] win_ofs;
    logic [ID_W:0]   win_sum;
    logic [ID_W-1:0] win_id;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rise_detect u_rise (
            .clk  (clk),
            .rstn (rstn),
            .lvl  (lvl[i]),
            .en   (en_mask[i]),
            .rise (rise[i])
        );
    end

    assign evt_valid = (state_p0 == PEA_OFFER);
    assign accept    = evt_valid & evt_ready;
    assign clr_vec   = accept ? (N_CH'(1) << evt_id) : '0;
    // A rise on a channel that stays pending is lost; a rise on the
    // channel being accepted this cycle becomes the next event instead.
    assign drop_vec  = rise & pending_p0 & ~clr_vec;
    assign any_drop  = |drop_vec;
    assign ptr_nxt   = (evt_id == ID_W'(N_CH - 1)) ? '0 : evt_id + 1'b1;
    assign busy      = (|pending_p0) | evt_valid;

    // Round-robin pick: rotate pending so ptr sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a channel index.
    always_comb begin
        rot       = N_CH'({pending_p0, pending_p0} >> ptr_p0);
        win_found = 1'b0;
        win_ofs   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                win_ofs   = ID_W'(k);
            end
        end
        win_sum = {1'b0, ptr_p0} + {1'b0, win_ofs};
        if (win_sum >= (ID_W + 1)'(N_CH)) win_sum = win_sum - (ID_W + 1)'(N_CH);
        win_id = win_sum[ID_W-1:0];
    end

    // Pending flags: accepted channel clears, new rises set.
    always_ff @(posedge clk) begin
        if (!rstn) pending_p0 <= '0;
        else       pending_p0 <= (pending_p0 & ~clr_vec) | rise;
    end

    // Offer FSM: load a winner from IDLE, hold it until accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_p0 <= PEA_IDLE;
            evt_id   <= '0;
            ptr_p0   <= '0;
        end else begin
            case (state_p0)
                PEA_IDLE: begin
                    if (win_found) begin
                        evt_id   <= win_id;
                        state_p0 <= PEA_OFFER;
                    end
                end
                PEA_OFFER: begin
                    if (evt_ready) begin
                        ptr_p0   <= ptr_nxt;
                        state_p0 <= PEA_IDLE;
                    end
                end
                default: state_p0 <= PEA_IDLE;
            endcase
        end
    end

    // Saturating drop counter; several drops in one cycle count once.
    always_ff @(posedge clk) begin
        if (!rstn)         drop_cnt <= '0;
        else if (drop_clr) drop_cnt <= any_drop ? CNT_W'(1) : '0;
        else if (any_drop) drop_cnt <= sat_inc(drop_cnt);
    end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter with a behavioural reference
// model compared every cycle plus literal spot checks.
module tb_pulse_event_arbiter;
    localparam int N   = 4;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  lvl;
    logic [N-1:0]  en_mask;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_ready;
    logic          busy;
    logic [CW-1:0] drop_cnt;
    logic          drop_clr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    pulse_event_arbiter #(.N_CH(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .lvl       (lvl),
        .en_mask   (en_mask),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-channel bits and integers, updated per edge
    bit m_prev [N];
    bit m_pend [N];
    bit m_rise [N];
    int m_ptr, m_id, m_drop;
    bit m_valid;
    bit m_acc, m_dropped;
    int m_aid, m_idx;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin m_prev[i] = 1; m_pend[i] = 0; end
            m_ptr = 0; m_id = 0; m_valid = 0; m_drop = 0;
        end else begin
            for (int i = 0; i < N; i++) m_rise[i] = lvl[i] && !m_prev[i] && en_mask[i];
            m_acc = m_valid && evt_ready;
            m_aid = m_id;
            m_dropped = 0;
            for (int i = 0; i < N; i++)
                if (m_rise[i] && m_pend[i] && !(m_acc && m_aid == i)) m_dropped = 1;
            if (!m_valid) begin
                for (int k = N - 1; k >= 0; k--) begin
                    m_idx = (m_ptr + k) % N;
                    if (m_pend[m_idx]) begin m_valid = 1; m_id = m_idx; end
                end
            end else if (m_acc) begin
                m_valid = 0;
                m_ptr = (m_aid + 1) % N;
            end
            if (m_acc) m_pend[m_aid] = 0;
            for (int i = 0; i < N; i++) if (m_rise[i]) m_pend[i] = 1;
            if (drop_clr)       m_drop = m_dropped ? 1 : 0;
            else if (m_dropped) m_drop = (m_drop < SAT) ? m_drop + 1 : SAT;
            for (int i = 0; i < N; i++) m_prev[i] = lvl[i];
        end
    end

    function automatic bit m_busy();
        bit b = m_valid;
        for (int i = 0; i < N; i++) b |= m_pend[i];
        return b;
    endfunction

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(evt_valid), 32'(m_valid));
            if (m_valid) check("id", 32'(evt_id), 32'(m_id));
            check("busy", 32'(busy), 32'(m_busy()));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstn = 0; lvl = 4'hF; en_mask = 4'hF; evt_ready = 0; drop_clr = 0;
        tick(2);
        chk_en = 1;
        rstn = 1;
        // reset with inputs held high
        tick(10);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // single event on ch2
        lvl = 4'h0; tick();
        evt_ready = 1; lvl = 4'b0100; tick();
        check("single_pend_busy", 32'(busy), 1);
        check("single_pend_valid", 32'(evt_valid), 0);
        tick();
        check("single_valid", 32'(evt_valid), 1);
        check("single_id", 32'(evt_id), 2);
        tick();
        check("single_done", 32'(evt_valid), 0);
        check("model_ptr", 32'(m_ptr), 3);

        // move ptr to 0 via a ch3 event
        lvl = 4'h0; tick();
        lvl = 4'b1000; tick(3);
        lvl = 4'h0; tick();
        // ptr=0, rises on ch0, ch1, ch3
        lvl = 4'b1011; tick(2);
        check("rr_a0", 32'(evt_id), 0);
        tick();
        check("rr_gap", 32'(evt_valid), 0);
        tick();
        check("rr_a1", 32'(evt_id), 1);
        tick(2);
        check("rr_a3", 32'(evt_id), 3);
        tick();
        // ptr=0, rises on ch0, ch2
        lvl = 4'h0; tick();
        lvl = 4'b0101; tick(2);
        check("rr_b0", 32'(evt_id), 0);
        tick(2);
        check("rr_b2", 32'(evt_id), 2);
        tick();
        // ch1 event moves ptr to 2
        lvl = 4'h0; tick();
        lvl = 4'b0010; tick(3);
        lvl = 4'h0; tick();
        lvl = 4'b0101; tick(2);
        check("rr_c2", 32'(evt_id), 2);
        tick(2);
        check("rr_c0", 32'(evt_id), 0);
        tick();
        lvl = 4'h0; tick();

        // backpressure and drop on ch1
        evt_ready = 0;
        lvl = 4'b0010; tick(2);
        check("bp_id0", 32'(evt_id), 1);
        lvl = 4'h0; tick();
        lvl = 4'b0010; tick();
        check("bp_drop", 32'(drop_cnt), 1);
        lvl = 4'h0; tick(4);
        check("bp_hold_valid", 32'(evt_valid), 1);
        check("bp_hold_id", 32'(evt_id), 1);
        // rise exactly on the accept edge: new event, no drop
        lvl = 4'b0010; evt_ready = 1; tick();
        check("acc_rise_valid", 32'(evt_valid), 0);
        check("acc_rise_busy", 32'(busy), 1);
        check("acc_rise_nodrop", 32'(drop_cnt), 1);
        tick();
        check("acc_rise_reoffer", 32'(evt_id), 1);
        tick();
        lvl = 4'h0; tick();

        // saturation and clear
        evt_ready = 0;
        drop_clr = 1; tick(); drop_clr = 0;
        check("clr_only", 32'(drop_cnt), 0);
        lvl = 4'b0001; tick(2);
        for (int d = 0; d < 5; d++) begin
            lvl = 4'h0; tick();
            lvl = 4'b0001; tick();
        end
        check("sat", 32'(drop_cnt), 3);
        lvl = 4'h0; tick();
        lvl = 4'b0001; drop_clr = 1; tick(); drop_clr = 0;
        check("clr_with_drop", 32'(drop_cnt), 1);
        lvl = 4'h0; tick();
        lvl = 4'b0100; tick();
        lvl = 4'h0; tick();
        lvl = 4'b0101; tick();
        check("multi_drop", 32'(drop_cnt), 2);
        lvl = 4'h0; evt_ready = 1; tick(2);
        check("multi_id2", 32'(evt_id), 2);
        tick();
        drop_clr = 1; tick(); drop_clr = 0;

        // masked channel produces nothing
        en_mask = 4'b1101; lvl = 4'b0010; tick(4);
        check("mask_valid", 32'(evt_valid), 0);
        check("mask_busy", 32'(busy), 0);
        lvl = 4'h0; en_mask = 4'hF; tick();
        // pending event survives a later mask
        lvl = 4'b1000; tick();
        en_mask = 4'b0111; tick();
        check("mask_pend_valid", 32'(evt_valid), 1);
        check("mask_pend_id", 32'(evt_id), 3);
        tick();
        lvl = 4'h0; en_mask = 4'hF; tick();

        // reset during OFFER
        evt_ready = 0;
        lvl = 4'b0100; tick(2);
        check("mid_id", 32'(evt_id), 2);
        lvl = 4'h0; tick();
        lvl = 4'b0100; tick();
        check("mid_drop", 32'(drop_cnt), 1);
        rstn = 0; tick();
        check("mid_rst_valid", 32'(evt_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        check("mid_rst_id", 32'(evt_id), 0);
        rstn = 1; tick(4);
        check("post_rst_valid", 32'(evt_valid), 0);
        check("post_rst_busy", 32'(busy), 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Collects rising-edge events from `N_CH` independent level inputs and serialises them onto one shared event port. Each channel runs its own rising-edge detector. Detected edges are held as per-channel pending flags. A round-robin arbiter offers them one at a time to a downstream consumer through a valid/ready handshake. The block sits between raw status/request levels and a single event-processing unit, and counts events lost to overrun.

## Interface
Parameters:
- `N_CH`, default 4: number of level input channels (≥2).
- `CNT_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `lvl`  in  N_CH: level inputs; already synchronous to `clk`.
- `en_mask`  in  N_CH: per-channel edge-detect enable.
- `evt_valid`  out  1: event offered (registered).
- `evt_id`  out  $clog2(N_CH): channel of the offered event (registered).
- `evt_ready`  in  1: consumer accepts the event.
- `busy`  out  1: `|pending | evt_valid`.
- `drop_cnt`  out  CNT_W: count of dropped events, saturating.
- `drop_clr`  in  1: clears `drop_cnt`.

## Operation
- Edge detect per channel:
  - `prev_q[i]` registers `lvl[i]`.
  - `rise[i] = lvl[i] & ~prev_q[i] & en_mask[i]`.
  - Reset sets `prev_q` to all ones, so an input held high through reset produces no event.
- Pending set:
  - `rise[i]` sets `pending[i]`.
  - If `pending[i]` is already set and is not cleared in the same cycle, the rise is dropped and `drop_cnt` increments.
  - A rise in the same cycle as the accept of channel i leaves `pending[i]` set; it counts as a new event, not a drop.
- Mask: `en_mask[i]=0` only suppresses new rises. An already-pending event on that channel is still served.
- FSM states: `IDLE`, `OFFER`.
  - **IDLE**: if any `pending` bit is set, select the winner by round-robin, load `evt_id`, set `evt_valid=1`, go to OFFER. Otherwise stay in IDLE.
  - **OFFER**: hold `evt_id` and `evt_valid` stable while `evt_ready=0`. On `evt_ready=1`:
    - clear `pending[evt_id]` (subject to the same-cycle-rise rule),
    - set `ptr <= (evt_id+1) mod N_CH`,
    - set `evt_valid <= 0`,
    - go to IDLE.
- Round-robin: search `ptr`, `ptr+1`, … wrapping to `ptr-1`; the first set `pending` bit wins. `ptr` resets to 0.
- Drop counter:
  - Saturates at `2^CNT_W-1`.
  - Multiple channels dropping in one cycle add 1 total.
  - `drop_clr` with no drop gives 0. `drop_clr` together with a drop gives 1.
- Reset (any cycle, including mid-OFFER), values after the edge:
  - `evt_valid=0`, `evt_id=0`, `busy=0`, `drop_cnt=0`
  - `pending=0`, `ptr=0`, state=IDLE, `prev_q` all ones.

## Timing
- `lvl[i]` sampled 1 at edge t (with `prev_q[i]=0`) → `pending[i]=1` after edge t → `evt_valid=1`, `evt_id=i` after edge t+1, if the FSM is in IDLE and i wins.
- Accept takes effect at the edge where `evt_valid & evt_ready` are both 1. `evt_valid` is 0 for at least one cycle after every accept.
- Peak throughput is one event per 2 cycles.
- `evt_ready` may be high before `evt_valid`. There is no combinational path from `evt_ready` to `evt_valid` or `evt_id`.
- `busy` is combinational from registered state only.

## Structure
- Package `pulse_event_arbiter_pkg`: FSM enum `pea_state_t {PEA_IDLE, PEA_OFFER}` and the `ptr`/`evt_id` width helper.
- Sub-module `rise_detect`, one instance per channel, holding `prev_q` and the enable gating. The arbiter, pending flags, FSM and counter stay in the top.

## Test plan
- **Reset with high inputs**: hold `lvl=4'b1111` through reset, then 10 cycles with `en_mask=4'hF` → `evt_valid=0`, `busy=0`, `drop_cnt=0`.
- **Single event**: `lvl[2]` 0→1 at edge t, `evt_ready=1` → `evt_valid=1`, `evt_id=2` after t+1; `evt_valid=0` after t+2; `ptr=3`.
- **Round-robin order**: `ptr=0`, simultaneous rises on ch0, ch1, ch3, `evt_ready=1` → ids 0, 1, 3 at 2-cycle spacing. After that, rises on ch0 and ch2 with `ptr=0`… then a case with `ptr=2` and rises on ch0 and ch2 → 2 first, then 0.
- **Backpressure and drop**: `evt_ready=0` for 6 cycles while ch1 is offered → `evt_id=1` stays stable. A second ch1 rise during that window gives `drop_cnt=1`. A ch1 rise exactly on the accept cycle gives a fresh ch1 offer two cycles later and no drop.
- **Counter saturation and clear**: with `CNT_W=2`, 5 drops → `drop_cnt=3`. `drop_clr` coinciding with a drop → `drop_cnt=1`.
- **Mask and mid-operation reset**:
  - `en_mask[1]=0` with a ch1 rise → no event.
  - A ch3 event pending, then `en_mask[3]` cleared → ch3 is still offered.
  - `rstn=0` for one cycle during OFFER → `evt_valid=0`, `pending=0` after that edge; no event follows.
